// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: 32x16 instruction store loaded during BOOT, then PC-driven fetch in RUN.
// Optional macro PC_RANGE_CHK_EN adds a sticky pc_fault output and blanks inst for PCs above 31.
module inst_fetch_unit (
   input  logic        clk,
   input  logic        Rst,
   input  logic        Pc_Rst,
   input  logic        Pc_Ld,
   input  logic        pc_addr_sel,
   input  logic [15:0] alu_pc_in,
   input  logic [15:0] imd_addr,
   input  logic        prog_we,
   input  logic [4:0]  prog_addr,
   input  logic [15:0] prog_data,
   input  logic        prog_done,
   output logic [15:0] inst,
   output logic [15:0] pc_out,
   output logic        running
`ifdef PC_RANGE_CHK_EN
   ,output logic       pc_fault
`endif
);

   typedef enum logic {BOOT, RUN} state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] inst_q, inst_d;
   logic        pc_ld_q, pc_ld_d;
   logic        ld_edge;
   logic [15:0] ld_val;
   logic [15:0] imem [32];
`ifdef PC_RANGE_CHK_EN
   logic        fault_q, fault_d;
`endif

   // Memory has no reset so a system reset keeps the loaded program.
   always_ff @(posedge clk) begin
      if (state_q == BOOT && prog_we) imem[prog_addr] <= prog_data;
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      pc_ld_d = pc_ld_q;
      ld_edge = Pc_Ld & ~pc_ld_q;
      ld_val  = pc_addr_sel ? imd_addr : alu_pc_in;
`ifdef PC_RANGE_CHK_EN
      fault_d = fault_q;
`endif
      case (state_q)
         BOOT: begin
            pc_d    = '0;
            inst_d  = '0;
            pc_ld_d = 1'b0;
            if (prog_done) state_d = RUN;
         end
         RUN: begin
            pc_ld_d = Pc_Ld;
`ifdef PC_RANGE_CHK_EN
            inst_d  = (|pc_q[15:5]) ? '0 : imem[pc_q[4:0]];
            if (Pc_Rst && ld_edge && (|ld_val[15:5])) fault_d = 1'b1;
`else
            inst_d  = imem[pc_q[4:0]];
`endif
            if (!Pc_Rst)      pc_d = '0;
            else if (ld_edge) pc_d = ld_val;
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= BOOT;
         pc_q    <= '0;
         inst_q  <= '0;
         pc_ld_q <= 1'b0;
`ifdef PC_RANGE_CHK_EN
         fault_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         pc_ld_q <= pc_ld_d;
`ifdef PC_RANGE_CHK_EN
         fault_q <= fault_d;
`endif
      end
   end

   assign inst    = inst_q;
   assign pc_out  = pc_q;
   assign running = (state_q == RUN);
`ifdef PC_RANGE_CHK_EN
   assign pc_fault = fault_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: behavioural model plus directed literal checks
// and a randomized run phase. Honors PC_RANGE_CHK_EN when defined.
module tb_inst_fetch_unit;

`ifdef PC_RANGE_CHK_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        Rst = 1'b0;
   logic        Pc_Rst = 1'b1;
   logic        Pc_Ld = 1'b0;
   logic        pc_addr_sel = 1'b0;
   logic [15:0] alu_pc_in = '0;
   logic [15:0] imd_addr = '0;
   logic        prog_we = 1'b0;
   logic [4:0]  prog_addr = '0;
   logic [15:0] prog_data = '0;
   logic        prog_done = 1'b0;
   logic [15:0] inst;
   logic [15:0] pc_out;
   logic        running;
`ifdef PC_RANGE_CHK_EN
   logic        pc_fault;
`endif

   int checks = 0;
   int errors = 0;

   inst_fetch_unit dut (
      .clk(clk), .Rst(Rst), .Pc_Rst(Pc_Rst), .Pc_Ld(Pc_Ld),
      .pc_addr_sel(pc_addr_sel), .alu_pc_in(alu_pc_in), .imd_addr(imd_addr),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .prog_done(prog_done), .inst(inst), .pc_out(pc_out), .running(running)
`ifdef PC_RANGE_CHK_EN
      , .pc_fault(pc_fault)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural reference: program store, mode flag, PC, fetched word, Pc_Ld history.
   logic [15:0] m_mem [32];
   bit          m_run = 1'b0;
   int unsigned m_pc = 0;
   logic [15:0] m_inst = '0;
   bit          m_prev = 1'b0;
   bit          m_fault = 1'b0;

   always @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         m_run   <= 1'b0;
         m_pc    <= 0;
         m_inst  <= '0;
         m_prev  <= 1'b0;
         m_fault <= 1'b0;
      end else if (!m_run) begin
         if (prog_we) m_mem[prog_addr] <= prog_data;
         if (prog_done) m_run <= 1'b1;
      end else begin
         m_inst <= (FAULT_EN && m_pc > 31) ? 16'h0000 : m_mem[m_pc % 32];
         m_prev <= Pc_Ld;
         if (!Pc_Rst) m_pc <= 0;
         else if (Pc_Ld && !m_prev) begin
            m_pc <= pc_addr_sel ? int'(imd_addr) : int'(alu_pc_in);
            if ((pc_addr_sel ? int'(imd_addr) : int'(alu_pc_in)) > 31) m_fault <= 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model pc_out", pc_out, 16'(m_pc));
      check("model inst", inst, m_inst);
      check("model running", {15'b0, running}, {15'b0, m_run});
`ifdef PC_RANGE_CHK_EN
      check("model pc_fault", {15'b0, pc_fault}, {15'b0, m_fault});
`endif
   end

   function automatic logic [15:0] word(input int unsigned i);
      if (i == 0) return 16'h2045;
      if (i == 1) return 16'h4123;
      return 16'hA000 | 16'(i);
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load(input logic [15:0] target);
      pc_addr_sel = 1'b1;
      imd_addr    = target;
      Pc_Ld       = 1'b1;
      tick();
      Pc_Ld       = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(); tick(); tick();
      check("reset pc_out", pc_out, 16'h0000);
      check("reset inst", inst, 16'h0000);
      check("reset running", {15'b0, running}, 16'h0000);
      Rst = 1'b1;
      tick();
      for (int unsigned i = 0; i < 32; i++) begin
         prog_we   = 1'b1;
         prog_addr = 5'(i);
         prog_data = word(i);
         prog_done = (i == 31);
         tick();
         if (i == 16) check("boot pc_out held", pc_out, 16'h0000);
      end
      prog_we = 1'b0;
      prog_done = 1'b0;
      check("running after done", {15'b0, running}, 16'h0001);
      check("inst first run cycle", inst, 16'h0000);
      tick();
      check("first fetch", inst, 16'h2045);

      pc_addr_sel = 1'b0;
      alu_pc_in   = 16'h0001;
      Pc_Ld       = 1'b1;
      tick();
      check("seq load", pc_out, 16'h0001);
      alu_pc_in = 16'h0003;
      tick();
      check("seq hold 2", pc_out, 16'h0001);
      tick();
      check("seq hold 3", pc_out, 16'h0001);
      check("seq fetch", inst, 16'h4123);
      Pc_Ld = 1'b0;
      tick();

      load(16'h0007);
      check("branch pc", pc_out, 16'h0007);
      check("branch inst", inst, 16'hA007);

      load(16'h0005);
      check("pre-prio pc", pc_out, 16'h0005);
      Pc_Rst = 1'b0;
      Pc_Ld  = 1'b1;
      tick();
      check("priority clear", pc_out, 16'h0000);
      Pc_Rst = 1'b1;
      Pc_Ld  = 1'b0;
      tick();

      load(16'h0025);
      check("range pc full", pc_out, 16'h0025);
`ifdef PC_RANGE_CHK_EN
      check("range inst blank", inst, 16'h0000);
      check("range fault", {15'b0, pc_fault}, 16'h0001);
`else
      check("range wrap inst", inst, 16'hA005);
`endif

      load(16'h001F);
      check("we+done write", inst, 16'hA01F);

      repeat (400) begin
         Pc_Ld       = 1'($urandom_range(0, 1));
         Pc_Rst      = ($urandom_range(0, 15) != 0);
         pc_addr_sel = 1'($urandom_range(0, 1));
         alu_pc_in   = $urandom_range(0, 3) != 0 ? 16'($urandom_range(0, 31)) : 16'($urandom);
         imd_addr    = $urandom_range(0, 3) != 0 ? 16'($urandom_range(0, 31)) : 16'($urandom);
         prog_we     = 1'($urandom_range(0, 1));
         prog_addr   = 5'($urandom);
         prog_data   = 16'($urandom);
         prog_done   = 1'($urandom_range(0, 1));
         tick();
      end
      Pc_Ld = 1'b0;
      Pc_Rst = 1'b1;
      prog_we = 1'b0;
      prog_done = 1'b0;
      tick(); tick();

      load(16'h0009);
      check("pre-reset pc", pc_out, 16'h0009);
      check("pre-reset inst", inst, 16'hA009);
      #2 Rst = 1'b0;
      #1;
      check("async rst pc", pc_out, 16'h0000);
      check("async rst running", {15'b0, running}, 16'h0000);
      check("async rst inst", inst, 16'h0000);
      tick();
      Rst = 1'b1;
      tick(); tick();
      check("wait boot", {15'b0, running}, 16'h0000);
      prog_we   = 1'b1;
      prog_addr = 5'd3;
      prog_data = 16'hBEEF;
      tick();
      prog_we   = 1'b0;
      prog_done = 1'b1;
      tick();
      prog_done = 1'b0;
      check("rerun running", {15'b0, running}, 16'h0001);
      load(16'h0009);
      check("imem kept", inst, 16'hA009);
      load(16'h0003);
      check("reboot write", inst, 16'hBEEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
